// File: rtl/pulse_seq.sv
// pulse_seq: plays a width/gap table as a pulse train into sigpulse, N passes or forever, abortable.
// Outputs are registered. Define PULSE_SEQ_TIMEOUT_EN to add the handshake watchdog that drives err.
module pulse_seq #(
  parameter int _RAM_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_W      = 16,
  parameter int REP_W      = 8,
  parameter int TIMEOUT    = 65535
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [_RAM_WIDTH-1:0] wr_width,
  input  logic [GAP_W-1:0]      wr_gap,
  input  logic [ADDR_W:0]       num_entries,
  input  logic [REP_W-1:0]      repeat_cnt,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  sp_valid,
  output logic                  sp_en,
  output logic [_RAM_WIDTH-1:0] sp_pulseWidth,
  output logic                  sp_dis,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     cur_idx,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_ACK, S_WAIT_DONE, S_GAP, S_FINISH
  } state_t;

  state_t                state, state_nx;
  logic [_RAM_WIDTH-1:0] tbl_width [DEPTH];
  logic [GAP_W-1:0]      tbl_gap   [DEPTH];
  logic [ADDR_W:0]       n_lat, n_nx;
  logic [REP_W-1:0]      rep_left, rep_nx;
  logic [GAP_W-1:0]      gap_cnt, gap_nx;
  logic [ADDR_W-1:0]     idx_nx;
  logic [_RAM_WIDTH-1:0] pw_nx;
  logic                  en_nx, dis_nx, done_nx, advance;

`ifdef PULSE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt, wd_nx;
  logic            err_nx;
`endif

  // Table is frozen while a sequence runs so a pass never sees a half-updated pattern.
  always_ff @(posedge io_clk) begin
    if (wr_en && !busy) begin
      tbl_width[wr_addr] <= wr_width;
      tbl_gap[wr_addr]   <= wr_gap;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = cur_idx;
    n_nx     = n_lat;
    rep_nx   = rep_left;
    gap_nx   = gap_cnt;
    pw_nx    = sp_pulseWidth;
    en_nx    = 1'b0;
    dis_nx   = 1'b0;
    done_nx  = 1'b0;
    advance  = 1'b0;
`ifdef PULSE_SEQ_TIMEOUT_EN
    err_nx   = err;
    wd_nx    = '0;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          idx_nx   = '0;
          n_nx     = num_entries;
          rep_nx   = repeat_cnt;
          state_nx = (num_entries == '0) ? S_FINISH : S_ARM;
`ifdef PULSE_SEQ_TIMEOUT_EN
          err_nx   = 1'b0;
`endif
        end
      end
      S_ARM: begin
        pw_nx = tbl_width[cur_idx];
        if (sp_valid) begin
          en_nx    = 1'b1;
          state_nx = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (!sp_valid) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (sp_valid) begin
          if (tbl_gap[cur_idx] == '0) begin
            advance = 1'b1;
          end else begin
            gap_nx   = tbl_gap[cur_idx] - 1'b1;
            state_nx = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) advance = 1'b1;
        else               gap_nx  = gap_cnt - 1'b1;
      end
      S_FINISH: begin
        done_nx  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    // rep_left of zero means the pattern loops until aborted.
    if (advance) begin
      if ({1'b0, cur_idx} != n_lat - 1'b1) begin
        idx_nx   = cur_idx + 1'b1;
        state_nx = S_ARM;
      end else if (rep_left == '0) begin
        idx_nx   = '0;
        state_nx = S_ARM;
      end else if (rep_left > REP_W'(1)) begin
        rep_nx   = rep_left - 1'b1;
        idx_nx   = '0;
        state_nx = S_ARM;
      end else begin
        state_nx = S_FINISH;
      end
    end

`ifdef PULSE_SEQ_TIMEOUT_EN
    if (state == S_WAIT_ACK || state == S_WAIT_DONE) begin
      wd_nx = wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
        state_nx = S_IDLE;
        dis_nx   = 1'b1;
        err_nx   = 1'b1;
      end
    end
`endif

    if (state != S_IDLE && abort) begin
      state_nx = S_IDLE;
      dis_nx   = 1'b1;
      en_nx    = 1'b0;
      done_nx  = 1'b0;
    end
  end

  // busy follows the next state so it drops together with the done pulse.
  always_ff @(posedge io_clk) begin
    if (!io_rst) begin
      state         <= S_IDLE;
      cur_idx       <= '0;
      n_lat         <= '0;
      rep_left      <= '0;
      gap_cnt       <= '0;
      sp_pulseWidth <= '0;
      sp_en         <= 1'b0;
      sp_dis        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      cur_idx       <= idx_nx;
      n_lat         <= n_nx;
      rep_left      <= rep_nx;
      gap_cnt       <= gap_nx;
      sp_pulseWidth <= pw_nx;
      sp_en         <= en_nx;
      sp_dis        <= dis_nx;
      busy          <= (state_nx != S_IDLE);
      done          <= done_nx;
    end
  end

`ifdef PULSE_SEQ_TIMEOUT_EN
  always_ff @(posedge io_clk) begin
    if (!io_rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      wd_cnt <= wd_nx;
      err    <= err_nx;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_seq.sv
// Randomized scoreboard bench for pulse_seq with a behavioural sigpulse responder.
module tb_pulse_seq;
  localparam int RW = 32, DEPTH = 16, AW = 4, GW = 16, RPW = 8, NW = AW + 1;
  localparam int EV_TRIG = 0, EV_DONE = 1, EV_DIS = 2;

  logic          io_clk = 1'b0;
  logic          io_rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [RW-1:0] wr_width = '0;
  logic [GW-1:0] wr_gap = '0;
  logic [NW-1:0] num_entries = '0;
  logic [RPW-1:0] repeat_cnt = '0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          sp_valid = 1'b1;
  logic          sp_en, sp_dis, busy, done, err;
  logic [RW-1:0] sp_pulseWidth;
  logic [AW-1:0] cur_idx;

  pulse_seq dut (
    .io_clk(io_clk), .io_rst(io_rst), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_width(wr_width), .wr_gap(wr_gap), .num_entries(num_entries),
    .repeat_cnt(repeat_cnt), .start(start), .abort(abort), .sp_valid(sp_valid),
    .sp_en(sp_en), .sp_pulseWidth(sp_pulseWidth), .sp_dis(sp_dis), .busy(busy),
    .done(done), .cur_idx(cur_idx), .err(err)
  );

  always #5 io_clk = ~io_clk;

  int cyc = 0;
  always @(posedge io_clk) cyc <= cyc + 1;

  typedef struct {
    int          kind;
    logic [31:0] width;
    int          idx;
    int          gap;
    int          at;   // absolute cycle, or -1: last rise + previous gap + 2
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] m_w [DEPTH];
  int          m_g [DEPTH];
  int          checks = 0, errors = 0;
  int          rise_cyc = 0, prev_gap = 0;
  bit          prev_en = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic [31:0] w, input int idx, input int gap, input int at);
    ev_t ev;
    ev.kind = kind; ev.width = w; ev.idx = idx; ev.gap = gap; ev.at = at;
    exp_q.push_back(ev);
  endtask

  task automatic take(input int kind);
    ev_t ev;
    int  want;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
      return;
    end
    ev = exp_q.pop_front();
    chk("event_kind", kind, ev.kind);
    want = (ev.at >= 0) ? ev.at : rise_cyc + prev_gap + 2;
    chk("event_cycle", cyc, want);
    if (kind == EV_TRIG) begin
      chk("trig_width", sp_pulseWidth, ev.width);
      chk("trig_idx", cur_idx, ev.idx);
      prev_gap = ev.gap;
    end else begin
      chk("busy_low_at_end", busy, 0);
    end
  endtask

  // Monitor: consumes the scoreboard whenever the DUT shows an event.
  initial begin : monitor
    forever begin
      @(negedge io_clk);
      if (io_rst) begin
        if (sp_en) begin
          chk("sp_en_single_cycle", prev_en, 0);
          take(EV_TRIG);
        end
        if (done)   take(EV_DONE);
        if (sp_dis) take(EV_DIS);
      end
      prev_en = sp_en;
    end
  end

  // sigpulse stand-in: drops valid after a random ack delay, raises it after a random pulse time.
  initial begin : responder
    int dly, len;
    forever begin
      @(negedge io_clk);
      if (sp_en) begin
        dly = $urandom_range(0, 2);
        len = $urandom_range(2, 6);
        repeat (dly + 1) @(posedge io_clk);
        #1 sp_valid = 1'b0;
        repeat (len) @(posedge io_clk);
        #1 sp_valid = 1'b1;
        rise_cyc = cyc;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge io_clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] w, input int g, input bit model);
    wr_en = 1'b1; wr_addr = AW'(a); wr_width = w; wr_gap = GW'(g);
    tick(1);
    wr_en = 1'b0;
    if (model) begin m_w[a] = w; m_g[a] = g; end
  endtask

  task automatic launch(input int n, input int rep, input int passes, input int first_off,
                        input bit exp_done, input int max_trig);
    int s, cnt;
    s = cyc; cnt = 0;
    if (n == 0) push_ev(EV_DONE, 0, 0, 0, s + 2);
    else begin
      for (int p = 0; p < passes; p++)
        for (int i = 0; i < n; i++)
          if (cnt < max_trig) begin
            push_ev(EV_TRIG, m_w[i], i, m_g[i], (cnt == 0) ? s + first_off : -1);
            cnt++;
          end
      if (exp_done) push_ev(EV_DONE, 0, 0, 0, -1);
    end
    num_entries = NW'(n); repeat_cnt = RPW'(rep); start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < limit) begin tick(1); k++; end
    checks++;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL %s: %0d events pending after %0d cycles, expected 0", name, exp_q.size(), limit);
      exp_q.delete();
    end
  endtask

  task automatic settle();
    int k;
    k = 0;
    while (!sp_valid && k < 100) begin tick(1); k++; end
    tick(3);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int n, rep, k;
    tick(3);
    chk("rst_sp_en", sp_en, 0);
    chk("rst_sp_dis", sp_dis, 0);
    chk("rst_pulse_width", sp_pulseWidth, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cur_idx", cur_idx, 0);
    chk("rst_err", err, 0);
    io_rst = 1'b1;
    tick(2);

    // Directed pattern: widths 1000/500/250, gaps 0/5/10, single pass.
    wr(0, 1000, 0, 1); wr(1, 500, 5, 1); wr(2, 250, 10, 1);
    launch(3, 1, 1, 2, 1, 99);
    drain("directed_3", 500);
    settle();

    // Two passes of two entries; a write while busy must not reach the table.
    launch(2, 2, 2, 2, 1, 99);
    tick(2);
    wr(0, 32'hDEAD_BEEF, 3, 0);
    drain("repeat_2", 500);
    settle();
    launch(1, 1, 1, 2, 1, 99);
    drain("table_unchanged", 200);
    settle();

    // Randomized tables, lengths and repeat counts.
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 4; i++) wr(i, $urandom, $urandom_range(0, 6), 1);
      n   = $urandom_range(1, 4);
      rep = $urandom_range(1, 3);
      launch(n, rep, rep, 2, 1, 99);
      drain("random_seq", 1500);
      settle();
    end

    // Infinite repeat: more than 10 passes, no done, then abort.
    launch(2, 0, 11, 2, 0, 22);
    drain("infinite", 3000);
    push_ev(EV_DIS, 0, 0, 0, cyc + 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(20);
    chk("infinite_abort_busy", busy, 0);
    settle();

    // Abort during WAIT_DONE of entry 1.
    launch(3, 1, 1, 2, 0, 2);
    drain("abort_prefix", 500);
    k = 0;
    while (sp_valid && k < 50) begin tick(1); k++; end
    tick(1);
    push_ev(EV_DIS, 0, 0, 0, cyc + 1);
    abort = 1'b1; tick(1); abort = 1'b0;
    tick(30);
    chk("abort_busy", busy, 0);
    drain("abort_dis", 10);
    settle();

    // sp_valid low at start: trigger only after it rises.
    sp_valid = 1'b0;
    tick(1);
    launch(1, 1, 1, 6, 1, 99);
    tick(4);
    sp_valid = 1'b1;
    drain("valid_held_low", 200);
    settle();

    // Empty pattern finishes without a trigger.
    launch(0, 1, 1, 2, 1, 99);
    drain("zero_entries", 20);
    settle();

    // start and abort together in IDLE: nothing happens.
    num_entries = NW'(2); repeat_cnt = RPW'(1); start = 1'b1; abort = 1'b1;
    tick(1);
    start = 1'b0; abort = 1'b0;
    tick(10);
    chk("idle_abort_busy", busy, 0);

    // Reset mid-sequence: outputs clear, no sp_dis.
    launch(2, 1, 1, 2, 1, 99);
    k = 0;
    while (exp_q.size() > 2 && k < 100) begin tick(1); k++; end
    io_rst = 1'b0;
    exp_q.delete();
    tick(1);
    chk("midrst_sp_en", sp_en, 0);
    chk("midrst_sp_dis", sp_dis, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cur_idx", cur_idx, 0);
    chk("midrst_pulse_width", sp_pulseWidth, 0);
    io_rst = 1'b1;
    settle();
    tick(10);
    chk("post_reset_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
